// File: rtl/mult_share_pkg.sv
// Shared types and constants for the two-requester shift-add multiplier.
// Holds the FSM state enum, the default operand width and requester indices.
package mult_share_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam int N_DEF = 8;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

endpackage

// File: rtl/mult_share_ctrl_datapath.sv
// Shift-add multiplier datapath: accumulator (hi), multiplier (lo), multiplicand.
// Ports: clock/reset, clear/load/shift strobes, a/b operands, result {hi, lo}.
module shift_add_datapath
    import mult_share_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           load,
    input  logic           shift,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] result
);

    logic [N-1:0] hi_q, hi_d;
    logic [N-1:0] lo_q, lo_d;
    logic [N-1:0] mc_q, mc_d;
    logic [N:0]   sum;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        mc_d = mc_q;
        // Carry lands in sum[N] and drops into hi[N-1] on the shift.
        sum = {1'b0, hi_q};
        if (lo_q[0]) begin
            sum = sum + {1'b0, mc_q};
        end
        if (clear) begin
            hi_d = '0;
        end
        if (load) begin
            mc_d = a;
            lo_d = b;
        end
        if (shift) begin
            hi_d = sum[N:1];
            lo_d = {sum[0], lo_q[N-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            mc_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            mc_q <= mc_d;
        end
    end

    assign result = {hi_q, lo_q};

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one shift-add multiplier.
// Ports: clock/reset, req[1:0], a0/b0/a1/b1 operands, grant, busy, done, product.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     req,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic [1:0]     grant,
    output logic           busy,
    output logic [1:0]     done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_q, last_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     done_q, done_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic           win;
    logic           last_step;
    logic           dp_clr, dp_ld, dp_sh;
    logic [N-1:0]   a_sel, b_sel;
    logic [2*N-1:0] result;

    assign last_step = (cnt_q == CW'(N - 1));

    // Tie goes to whoever was not served last.
    always_comb begin
        unique case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~last_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = CLEAR;
            CLEAR:   state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dp_clr  = 1'b0;
        dp_ld   = 1'b0;
        dp_sh   = 1'b0;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        done_d  = '0;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    last_d       = win;
                end
            end
            CLEAR: dp_clr = 1'b1;
            LOAD: begin
                dp_ld = 1'b1;
                cnt_d = '0;
            end
            SHIFT: begin
                dp_sh = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // Registered so the pulse lines up with the DONE cycle.
                if (last_step) begin
                    done_d = grant_q;
                end
            end
            DONE: begin
                prod_d  = result;
                grant_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            last_q  <= 1'b1;
            grant_q <= '0;
            done_q  <= '0;
            prod_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign a_sel = grant_q[REQ1] ? a1 : a0;
    assign b_sel = grant_q[REQ1] ? b1 : b0;

    shift_add_datapath #(
        .N(N)
    ) u_dp (
        .clock  (clock),
        .reset  (reset),
        .clear  (dp_clr),
        .load   (dp_ld),
        .shift  (dp_sh),
        .a      (a_sel),
        .b      (b_sel),
        .result (result)
    );

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl (N=8).
// Vector table, corner sequences and a random run against a transaction model.
module tb_mult_share_ctrl;

    localparam int N = 8;

    logic           clock;
    logic           reset;
    logic [1:0]     req;
    logic [N-1:0]   a0, b0, a1, b1;
    logic [1:0]     grant;
    logic           busy;
    logic [1:0]     done;
    logic [2*N-1:0] product;

    int errs;
    int checks;

    mult_share_ctrl #(
        .N(N)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  rq;
        logic [7:0]  va0;
        logic [7:0]  vb0;
        logic [7:0]  va1;
        logic [7:0]  vb1;
        logic [1:0]  eg;
        logic [15:0] ep;
    } vec_t;

    vec_t vt[8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req   = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    // Called at a sample point inside an IDLE cycle with req already set.
    // act 1: scramble all operands; act 2: withdraw all requests.
    task automatic run_op(input string nm, input logic [1:0] eg,
                          input logic [15:0] ep, input bit drop,
                          input int act_cyc, input int act);
        for (int c = 1; c <= N + 4; c++) begin
            step();
            if (c <= N + 3) begin
                chk({nm, " grant"}, 32'(grant), 32'(eg));
                chk({nm, " busy"}, 32'(busy), 32'd1);
                chk({nm, " done"}, 32'(done),
                    (c == N + 3) ? 32'(eg) : 32'd0);
            end else begin
                chk({nm, " grant_end"}, 32'(grant), 32'd0);
                chk({nm, " busy_end"}, 32'(busy), 32'd0);
                chk({nm, " done_end"}, 32'(done), 32'd0);
                chk({nm, " product"}, 32'(product), 32'(ep));
            end
            if (c == N + 3 && drop) req = 2'b00;
            if (c == act_cyc) begin
                if (act == 1) begin
                    a0 = 8'd1;
                    b0 = 8'd1;
                    a1 = 8'd1;
                    b1 = 8'd1;
                end else if (act == 2) begin
                    req = 2'b00;
                end
            end
        end
    endtask

    int          ph;
    int          own;
    int          mlast;
    logic [15:0] mprod;
    logic [7:0]  ca, cb;
    int          cool[2];

    initial begin
        errs   = 0;
        checks = 0;
        req    = 2'b00;
        reset  = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        vt[0] = '{2'b01, 8'd13,  8'd11,  8'd0,   8'd0,   2'b01, 16'd143};
        vt[1] = '{2'b01, 8'd0,   8'd200, 8'd0,   8'd0,   2'b01, 16'd0};
        vt[2] = '{2'b10, 8'd0,   8'd0,   8'd200, 8'd1,   2'b10, 16'd200};
        vt[3] = '{2'b11, 8'd255, 8'd255, 8'd3,   8'd7,   2'b01, 16'd65025};
        vt[4] = '{2'b11, 8'd255, 8'd255, 8'd3,   8'd7,   2'b10, 16'd21};
        vt[5] = '{2'b10, 8'd0,   8'd0,   8'd255, 8'd255, 2'b10, 16'd65025};
        vt[6] = '{2'b11, 8'd2,   8'd128, 8'd1,   8'd1,   2'b01, 16'd256};
        vt[7] = '{2'b01, 8'd255, 8'd1,   8'd0,   8'd0,   2'b01, 16'd255};

        reset_dut();
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst product", 32'(product), 32'd0);

        for (int i = 0; i < 8; i++) begin
            req = vt[i].rq;
            a0  = vt[i].va0;
            b0  = vt[i].vb0;
            a1  = vt[i].va1;
            b1  = vt[i].vb1;
            run_op($sformatf("vec%0d", i), vt[i].eg, vt[i].ep, 1'b1, 0, 0);
        end

        // Both requesters hold req: grants alternate 0,1,0.
        reset_dut();
        req = 2'b11;
        a0 = 8'd255; b0 = 8'd255; a1 = 8'd3; b1 = 8'd7;
        run_op("alt1", 2'b01, 16'd65025, 1'b0, 0, 0);
        run_op("alt2", 2'b10, 16'd21, 1'b0, 0, 0);
        run_op("alt3", 2'b01, 16'd65025, 1'b1, 0, 0);

        // Operands scrambled after LOAD must not matter.
        req = 2'b01;
        a0 = 8'd9; b0 = 8'd9;
        run_op("opflip", 2'b01, 16'd81, 1'b1, 4, 1);

        // Reset in SHIFT cycle 5.
        req = 2'b01;
        a0 = 8'd5; b0 = 8'd5;
        for (int c = 0; c < 5; c++) step();
        reset = 1'b1;
        req   = 2'b00;
        step();
        chk("midrst grant", 32'(grant), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst product", 32'(product), 32'd0);
        reset = 1'b0;
        req = 2'b10;
        a1 = 8'd12; b1 = 8'd12;
        run_op("postrst", 2'b10, 16'd144, 1'b1, 0, 0);

        // Withdrawn request still completes and still moves the pointer.
        req = 2'b01;
        a0 = 8'd3; b0 = 8'd4;
        run_op("wd_pre", 2'b01, 16'd12, 1'b1, 0, 0);
        req = 2'b10;
        a1 = 8'd7; b1 = 8'd6;
        run_op("withdraw", 2'b10, 16'd42, 1'b0, 5, 2);
        req = 2'b11;
        a0 = 8'd10; b0 = 8'd10; a1 = 8'd9; b1 = 8'd9;
        run_op("wd_tie", 2'b01, 16'd100, 1'b1, 0, 0);

        // Random traffic against a transaction-level model.
        reset_dut();
        ph = -1; own = 0; mlast = 1; mprod = '0; ca = '0; cb = '0;
        cool[0] = 0; cool[1] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (ph == N + 3 && own == r) begin
                    req[r]  = 1'b0;
                    cool[r] = int'($urandom_range(0, 3));
                end else if (!req[r]) begin
                    if (cool[r] > 0) begin
                        cool[r]--;
                    end else if ($urandom_range(0, 2) == 0) begin
                        req[r] = 1'b1;
                        if (r == 0) begin
                            a0 = 8'($urandom); b0 = 8'($urandom);
                        end else begin
                            a1 = 8'($urandom); b1 = 8'($urandom);
                        end
                    end
                end else if (ph >= 3 && own == r) begin
                    if ($urandom_range(0, 15) == 0) begin
                        req[r]  = 1'b0;
                        cool[r] = N + 2;
                    end else if ($urandom_range(0, 3) == 0) begin
                        if (r == 0) begin
                            a0 = 8'($urandom); b0 = 8'($urandom);
                        end else begin
                            a1 = 8'($urandom); b1 = 8'($urandom);
                        end
                    end
                end
            end
            if (ph < 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) own = 1 - mlast;
                    else own = req[1] ? 1 : 0;
                    mlast = own;
                    ph = 1;
                end
            end else if (ph == N + 3) begin
                ph = -1;
                mprod = 16'(ca) * 16'(cb);
            end else begin
                if (ph == 2) begin
                    ca = (own == 1) ? a1 : a0;
                    cb = (own == 1) ? b1 : b0;
                end
                ph++;
            end
            step();
            chk("rnd grant", 32'(grant),
                (ph >= 1) ? ((own == 1) ? 32'd2 : 32'd1) : 32'd0);
            chk("rnd busy", 32'(busy), (ph >= 1) ? 32'd1 : 32'd0);
            chk("rnd done", 32'(done),
                (ph == N + 3) ? ((own == 1) ? 32'd2 : 32'd1) : 32'd0);
            chk("rnd product", 32'(product), 32'(mprod));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
